// File: rtl/fetch_pkg.sv
// Shared defaults and the default FIFO entry type for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned XLEN_DEF         = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0040_0000;
  localparam int unsigned INCR_DEF         = 4;
  localparam int unsigned INST_W           = 32;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [INST_W-1:0]   inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, inst} entries; flush wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned OW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  entry_t        wdata_i,
  input  logic          pop_i,
  output entry_t        rdata_o,
  output logic          valid_o,
  output logic [OW-1:0] occ_o
);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          pop_s;

  assign valid_o = (occ_q != {OW{1'b0}});
  assign pop_s   = pop_i && valid_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush_i) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      occ_d    = {OW{1'b0}};
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1'b1);
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + AW'(1'b1);
      else        rd_ptr_d = rd_ptr_q;
      case ({push_i, pop_s})
        2'b10:   occ_d = occ_q + OW'(1'b1);
        2'b01:   occ_d = occ_q - OW'(1'b1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      occ_q    <= {OW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: PC, one-cycle ROM fetch, redirect handling, fetch FIFO.
// Define FETCH_ALIGN_CHECK_EN to flag misaligned redirects and halt fetch until reset.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter int unsigned     INCR         = INCR_DEF,
  parameter int unsigned     DEPTH        = 2
) (
  input  logic              clock,
  input  logic              reset,
  output logic [XLEN-1:0]   imem_addr,
  output logic              imem_rden,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [31:0]       out_inst,
  output logic              align_err
);

  localparam int unsigned     OW       = $clog2(DEPTH + 1);
  localparam logic [OW:0]     DEPTH_W  = (OW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INCR - 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } entry_t;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic            inflight_epoch_q, inflight_epoch_d;
  logic            epoch_q, epoch_d;

  logic [OW-1:0]   occ_s;
  logic [OW:0]     fill_s;
  logic            pop_s, push_s, issue_s, halted_s;
  logic [XLEN-1:0] target_pc_s;
  entry_t          push_entry_s, head_s;

  // Outstanding fetches count against capacity so a response always has a slot.
  assign fill_s      = {1'b0, occ_s} + {{OW{1'b0}}, inflight_q};
  assign pop_s       = out_valid && out_ready;
  assign issue_s     = reset && !redirect_valid && !halted_s && ((fill_s < DEPTH_W) || pop_s);
  assign push_s      = inflight_q && (inflight_epoch_q == epoch_q) && !redirect_valid;
  assign target_pc_s = redirect_pc & ~LOW_MASK;

  assign push_entry_s.pc   = inflight_pc_q;
  assign push_entry_s.inst = imem_data;

  assign imem_addr = pc_q;
  assign imem_rden = issue_s;
  assign out_pc    = out_valid ? head_s.pc   : {XLEN{1'b0}};
  assign out_inst  = out_valid ? head_s.inst : 32'h0000_0000;

  always_comb begin
    pc_d             = pc_q;
    inflight_d       = issue_s;
    inflight_pc_d    = inflight_pc_q;
    inflight_epoch_d = inflight_epoch_q;
    epoch_d          = epoch_q;
    if (redirect_valid) begin
      pc_d    = target_pc_s;
      epoch_d = ~epoch_q;
    end else if (issue_s) begin
      pc_d             = pc_q + XLEN'(INCR);
      inflight_pc_d    = pc_q;
      inflight_epoch_d = epoch_q;
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q             <= RESET_VECTOR;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= {XLEN{1'b0}};
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_epoch_q <= inflight_epoch_d;
      epoch_q          <= epoch_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic align_err_q, align_err_d;
  logic misaligned_s;

  assign misaligned_s = |(redirect_pc & LOW_MASK);

  // Sticky: once a misaligned redirect is seen, fetch stays halted until reset.
  always_comb begin
    align_err_d = align_err_q;
    if (redirect_valid && misaligned_s) align_err_d = 1'b1;
    else                                align_err_d = align_err_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) align_err_q <= 1'b0;
    else        align_err_q <= align_err_d;
  end

  assign halted_s  = align_err_q;
  assign align_err = align_err_q;
`else
  assign halted_s  = 1'b0;
  assign align_err = 1'b0;
`endif

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .flush_i (redirect_valid),
    .push_i  (push_s),
    .wdata_i (push_entry_s),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .valid_o (out_valid),
    .occ_o   (occ_s)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: expected PCs are queued up front, a monitor checks every pop.
module tb_pc_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rden;
  logic [31:0] imem_data = 32'h0000_0000;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0000_0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        align_err;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];

  pc_fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rden      (imem_rden),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .align_err      (align_err)
  );

  always #5 clock = ~clock;

  // ROM model: one-cycle latency, contents are the inverted address.
  always @(posedge clock) begin
    if (imem_rden) imem_data <= ~imem_addr;
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  // Monitor: every accepted head must match the next queued expectation.
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got pc %08h expected no delivery", out_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk32("out_pc", out_pc, e);
        chk32("out_inst", out_inst, ~e);
      end
    end
  end

  initial begin
    // Sequence 1: release, stall from C2 for 10 cycles, resume, stall until full, async reset.
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h0040_0000 + 32'(4 * i));
    out_ready = 1'b1;
    cyc(); cyc(); mid();
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_rden", imem_rden, 1'b0);
    chk32("rst_addr", imem_addr, 32'h0040_0000);
    chk1("rst_align_err", align_err, 1'b0);

    cyc(); reset = 1'b1; mid();                       // C0
    chk1("c0_rden", imem_rden, 1'b1);
    chk32("c0_addr", imem_addr, 32'h0040_0000);
    chk1("c0_out_valid", out_valid, 1'b0);
    cyc(); mid();                                     // C1
    chk1("c1_out_valid", out_valid, 1'b0);
    cyc(); out_ready = 1'b0; mid();                   // C2
    chk1("c2_out_valid", out_valid, 1'b1);
    chk32("c2_out_pc", out_pc, 32'h0040_0000);
    chk1("c2_rden", imem_rden, 1'b0);
    for (int k = 3; k <= 11; k++) begin
      cyc(); mid();
      chk1("stall_rden", imem_rden, 1'b0);
      chk32("stall_addr", imem_addr, 32'h0040_0008);
      chk32("stall_head", out_pc, 32'h0040_0000);
    end
    for (int k = 12; k <= 19; k++) begin
      cyc(); out_ready = 1'b1; mid();
      chk1("resume_no_bubble", out_valid, 1'b1);
    end
    cyc(); out_ready = 1'b0; mid();                   // C20
    cyc(); mid();                                     // C21
    chk1("full_valid", out_valid, 1'b1);
    chk32("full_head", out_pc, 32'h0040_0020);
    chk32("full_addr", imem_addr, 32'h0040_0028);
    chk1("full_rden", imem_rden, 1'b0);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk1("async_rst_valid", out_valid, 1'b0);
    chk1("async_rst_rden", imem_rden, 1'b0);
    chk32("async_rst_addr", imem_addr, 32'h0040_0000);

    // Sequence 2: redirect over an in-flight fetch, PC wrap, misaligned redirect.
    exp_q.push_back(32'h0040_0000);
    exp_q.push_back(32'h0040_0004);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'h0040_0100 + 32'(4 * i));
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
`ifndef FETCH_ALIGN_CHECK_EN
    exp_q.push_back(32'h0040_0100);
    exp_q.push_back(32'h0040_0104);
`endif
    cyc(); cyc();
    cyc(); reset = 1'b1; out_ready = 1'b1; mid();     // C0
    chk32("rel_addr", imem_addr, 32'h0040_0000);
    chk1("rel_rden", imem_rden, 1'b1);
    cyc(); cyc();                                     // C1, C2
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h0040_0100; mid();   // C3
    chk1("redir_rden", imem_rden, 1'b0);
    cyc(); redirect_valid = 1'b0; mid();              // C4
    chk1("redir_n1_valid", out_valid, 1'b0);
    chk32("redir_n1_addr", imem_addr, 32'h0040_0100);
    chk1("redir_n1_rden", imem_rden, 1'b1);
    cyc(); mid();                                     // C5
    chk1("redir_n2_valid", out_valid, 1'b0);
    cyc(); mid();                                     // C6
    chk1("redir_n3_valid", out_valid, 1'b1);
    cyc(); cyc(); cyc();                              // C7..C9
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;          // C10
    cyc(); redirect_valid = 1'b0; mid();              // C11
    chk32("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    chk1("wrap_valid0", out_valid, 1'b0);
    cyc(); mid();                                     // C12
    chk32("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    cyc(); mid();                                     // C13
    chk32("wrap_addr2", imem_addr, 32'h0000_0000);
    chk1("wrap_align_err", align_err, 1'b0);
    chk1("wrap_valid3", out_valid, 1'b1);
    for (int k = 14; k <= 17; k++) cyc();
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h0040_0102;          // C18
    cyc(); redirect_valid = 1'b0; mid();              // C19
`ifdef FETCH_ALIGN_CHECK_EN
    chk1("mis_align_err", align_err, 1'b1);
    chk1("mis_rden", imem_rden, 1'b0);
    for (int k = 20; k <= 22; k++) begin
      cyc(); mid();
      chk1("halt_rden", imem_rden, 1'b0);
      chk1("halt_valid", out_valid, 1'b0);
    end
`else
    chk1("mis_align_err", align_err, 1'b0);
    chk32("mis_addr", imem_addr, 32'h0040_0100);
    chk1("mis_rden", imem_rden, 1'b1);
    chk1("mis_valid", out_valid, 1'b0);
    cyc(); mid();                                     // C20
    chk1("mis_n2_valid", out_valid, 1'b0);
    cyc(); mid();                                     // C21
    chk1("mis_n3_valid", out_valid, 1'b1);
    cyc();                                            // C22
`endif
    cyc(); out_ready = 1'b0; mid();                   // C23
    chk32("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
